neuron_sequencer: RTL
=====================

Name: neuron_sequencer

Overview:
Sequences one neuron evaluation: streams N_INPUTS (activation, weight) pairs through a signed MAC, adds the scaled bias, applies the layer shift, then runs the ReLU/8-bit saturating activation stage. It sits between the layer controller, which issues start and ctrl_data, and the layer output buffer, which consumes out/out_valid. It gates the activation stage's ready signal so that out is only meaningful for one cycle per neuron.

Parameters:
WIDTH, 32, accumulator and activation-stage input width in bits.
N_INPUTS, 16, number of MAC operations per neuron (≥1).
CNT_W, $clog2(N_INPUTS+1), input counter width.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous reset, active-high.
start  input  1  pulse; begins a neuron evaluation, accepted only in IDLE.
ctrl_data  input  2  layer mode, latched at start; 00/01 = hidden layers (shift), 10/11 = output layer (no shift).
bias  input  8  signed bias, latched at start.
in_valid  input  1  x_in/w_in valid.
in_ready  output  1  high in ACC; a pair transfers when in_valid && in_ready.
x_in  input  8  unsigned activation.
w_in  input  8  signed weight.
busy  output  1  high in every state except IDLE.
out  output  8  activation result, {1'b0, 7-bit magnitude}.
out_valid  output  1  one-cycle pulse with out.

Behaviour:
- Reset: state=IDLE; acc, count, out, out_valid, in_ready, busy all 0. Reset mid-evaluation aborts with no out_valid.
- States: IDLE -> ACC -> BIAS -> ACT -> IDLE.
- IDLE: on start, latch ctrl_data and bias, clear acc and count, go to ACC. start in any other state is ignored.
- ACC: per transfer, acc += sext(signed({1'b0,x_in}) * w_in) and count++. The transfer carrying count==N_INPUTS-1 moves the FSM to BIAS. in_valid low means stall; no timeout.
- BIAS: acc += sext(bias*127), a 16-bit signed product. If the latched ctrl_data is 00 or 01, acc <= (acc+bias_term) >>> 9 (arithmetic shift); otherwise acc <= acc+bias_term.
- ACT: the activation stage is fed acc with ready=1. If acc ≤ 0, out=0. If acc > 127, out=8'h7F. Otherwise out={1'b0, acc[6:0]}. out and out_valid are registered, so out_valid is high exactly one cycle, in the cycle after ACT. Return to IDLE.
- out holds its last value until the next ACT; it is not cleared by out_valid falling.
- Latency from start to out_valid = N_INPUTS + 3 cycles with in_valid held high.
- start may be asserted in the same cycle out_valid is high; the FSM is in IDLE then, so back-to-back neurons are supported.
- Accumulation uses WIDTH-bit two's complement and wraps silently on overflow, unless the optional feature below is enabled.

Optional Feature:
NEURON_ACC_SAT_EN
- Defined: each ACC and BIAS addition saturates to the signed WIDTH-bit limits (0x7FFF_FFFF / 0x8000_0000 for WIDTH=32).
- Undefined: the additions wrap modulo 2^WIDTH.

Decomposition:
- Shared package nn_pkg: the state enum (S_IDLE, S_ACC, S_BIAS, S_ACT), the ctrl_data mode constants (MODE_HID0=2'b00, MODE_HID1=2'b01, MODE_OUT0=2'b10, MODE_OUT1=2'b11), BIAS_SCALE=127, HID_SHIFT=9, ACT_MAX=8'h7F.
- One sub-module, relu_sat8: a combinational ReLU/saturate from WIDTH bits to 8 bits with a ready gate. The sequencer registers its output.

Test Plan:
- ctrl_data=10, bias=0, N_INPUTS=16, all x_in=2, w_in=3 -> acc=96; out=8'h60, out_valid pulses at cycle 19 after start.
- ctrl_data=00, bias=4, all x_in=100, w_in=5 -> (8000+508)>>>9=16; out=8'h10.
- ctrl_data=10, bias=-1, all x_in=1, w_in=-1 -> acc=-143; out=0 with out_valid high.
- ctrl_data=11, bias=0, all x_in=255, w_in=127 -> out=8'h7F (saturated). With NEURON_ACC_SAT_EN, using WIDTH=16, acc clamps to 0x7FFF and out=8'h7F.
- Toggle in_valid every other cycle -> identical result to the continuous case, latency extended by the stall count; a start during ACC is ignored.
- Assert rst during ACC (count=7) -> next cycle: IDLE, busy=0, out=0, no out_valid. A fresh start then computes correctly.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types and constants for the neuron datapath.
// NEURON_ACC_SAT_EN (in neuron_sequencer) selects saturating accumulation.
package nn_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_BIAS,
    S_ACT
  } state_e;

  localparam logic [1:0] MODE_HID0 = 2'b00;
  localparam logic [1:0] MODE_HID1 = 2'b01;
  localparam logic [1:0] MODE_OUT0 = 2'b10;
  localparam logic [1:0] MODE_OUT1 = 2'b11;

  localparam int         BIAS_SCALE = 127;
  localparam int         HID_SHIFT  = 9;
  localparam logic [7:0] ACT_MAX    = 8'h7F;

  function automatic logic is_hidden(input logic [1:0] m);
    return (m == MODE_HID0) || (m == MODE_HID1);
  endfunction

endpackage

// File: rtl/relu_sat8.sv
// ReLU plus saturation from a WIDTH-bit signed value to an 8-bit
// activation {0, mag[6:0]}; output forced to zero while ready is low.
module relu_sat8
  import nn_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             ready,
  input  logic [WIDTH-1:0] din,
  output logic [7:0]       dout
);

  logic neg;
  logic zero;
  logic big;

  assign neg  = din[WIDTH-1];
  assign zero = (din == '0);
  assign big  = |din[WIDTH-2:7];

  always_comb begin
    dout = '0;
    if (ready && !neg && !zero) begin
      if (big) dout = ACT_MAX;
      else     dout = {1'b0, din[6:0]};
    end
  end

endmodule

// File: rtl/neuron_sequencer.sv
// One neuron evaluation: MAC over N_INPUTS pairs, bias, shift, activation.
// Define NEURON_ACC_SAT_EN for saturating (instead of wrapping) accumulation.
module neuron_sequencer
  import nn_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int N_INPUTS = 16,
  parameter int CNT_W    = $clog2(N_INPUTS + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] ctrl_data,
  input  logic [7:0] bias,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] x_in,
  input  logic [7:0] w_in,
  output logic       busy,
  output logic [7:0] out,
  output logic       out_valid
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);
  localparam logic signed [15:0] BIAS_K = 16'(BIAS_SCALE);

  state_e state_q, state_d;

  logic signed [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [1:0]              mode_q, mode_d;
  logic signed [7:0]       bias_q, bias_d;
  logic [7:0]              out_q, out_d;
  logic                    out_valid_q, out_valid_d;

  logic                    xfer;
  logic                    act_ready;
  logic [7:0]              act_out;
  logic signed [16:0]      prod;
  logic signed [15:0]      bias_prod;
  logic signed [WIDTH-1:0] bias_sum;

  function automatic logic signed [WIDTH-1:0] acc_add(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
`ifdef NEURON_ACC_SAT_EN
    logic [WIDTH:0] s;
    s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    if (s[WIDTH] != s[WIDTH-1])
      return s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                      : {1'b0, {(WIDTH-1){1'b1}}};
    return s[WIDTH-1:0];
`else
    return a + b;
`endif
  endfunction

  assign prod      = $signed({1'b0, x_in}) * $signed(w_in);
  assign bias_prod = bias_q * BIAS_K;
  assign bias_sum  = acc_add(acc_q, WIDTH'(bias_prod));
  assign xfer      = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      mode_q      <= '0;
      bias_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      bias_q      <= bias_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_ACC;
      S_ACC:  if (xfer && cnt_q == LAST) state_d = S_BIAS;
      S_BIAS: state_d = S_ACT;
      S_ACT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_ACC);
    busy      = (state_q != S_IDLE);
    act_ready = (state_q == S_ACT);
  end

  relu_sat8 #(.WIDTH(WIDTH)) u_act (
    .ready(act_ready),
    .din  (acc_q),
    .dout (act_out)
  );

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    bias_d      = bias_q;
    out_d       = act_ready ? act_out : out_q;
    out_valid_d = act_ready;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d = ctrl_data;
          bias_d = bias;
          acc_d  = '0;
          cnt_d  = '0;
        end
      end
      S_ACC: begin
        if (xfer) begin
          acc_d = acc_add(acc_q, WIDTH'(prod));
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BIAS: begin
        // Hidden layers rescale into activation range
        acc_d = is_hidden(mode_q) ? (bias_sum >>> HID_SHIFT) : bias_sum;
      end
      default: ;
    endcase
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule
